// File: rtl/alu_pkg.sv
// Shared types for the digit-serial accumulator ALU.
// Holds the opcode encoding and the FSM state type.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_LOAD = 3'd5,
    OP_CLR  = 3'd6,
    OP_PASS = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(op_t o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_digit_slice.sv
// One DIGIT-bit slice of the serial ALU datapath.
// Ripple full-adder chain; b is inverted for SUB.
module alu_digit_slice
  import alu_pkg::*;
#(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  input  op_t              op,
  output logic [DIGIT-1:0] res,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT-1:0] bx;
  logic [DIGIT-1:0] sum;
  logic [DIGIT:0]   c;

  always_comb begin
    bx   = b ^ {DIGIT{op == OP_SUB}};
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) |
                 (c[i] & (a[i] ^ bx[i]));
    end
  end

  assign cout = c[DIGIT];
  assign cmsb = c[DIGIT-1];

  always_comb begin
    res = '0;
    unique case (op)
      OP_ADD:  res = sum;
      OP_SUB:  res = sum;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_LOAD: res = b;
      OP_CLR:  res = '0;
      OP_PASS: res = a;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu_serial_acc.sv
// Digit-serial accumulator ALU, LS digit first.
// Define ALU_SAT_EN to clamp ADD/SUB on signed overflow.
module alu_serial_acc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % DIGIT != 0) begin : g_chk
    $error("WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  op_t              op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] res_fin;
  logic [DIGIT-1:0] dig;
  logic             cy;
  logic             d_cout;
  logic             d_cmsb;
  logic             accept;
  logic             last;
  logic             arith;
  logic             ovf;

  assign accept = in_valid && in_ready;
  assign last   = (state == ST_RUN) &&
                  (cnt == CW'(N - 1));
  assign arith  = is_arith(op_q);
  assign ovf    = arith && (d_cmsb ^ d_cout);

  alu_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .a    (a_sh[DIGIT-1:0]),
    .b    (b_sh[DIGIT-1:0]),
    .cin  (cy),
    .op   (op_q),
    .res  (dig),
    .cout (d_cout),
    .cmsb (d_cmsb)
  );

  // Final digit lands on top of the already-shifted partials
  assign res_full = (r_sh >> DIGIT) |
                    (WIDTH'(dig) << (WIDTH - DIGIT));

`ifdef ALU_SAT_EN
  // Wrapped MSB set means the true result was positive
  always_comb begin
    res_fin = res_full;
    if (ovf)
      res_fin = res_full[WIDTH-1] ?
                {1'b0, {(WIDTH-1){1'b1}}} :
                {1'b1, {(WIDTH-1){1'b0}}};
  end
`else
  assign res_fin = res_full;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_RUN;
      ST_RUN:  if (last)   state_nx = ST_DONE;
      ST_DONE:             state_nx = ST_IDLE;
      default:             state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= OP_ADD;
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cy       <= 1'b0;
      acc      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= op_t'(op);
      a_sh <= acc;
      b_sh <= operand;
      r_sh <= '0;
      cy   <= (op_t'(op) == OP_SUB);
    end else if (state == ST_RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      r_sh <= res_full;
      cy   <= d_cout;
      if (last) begin
        cnt      <= '0;
        acc      <= res_fin;
        carry    <= arith && d_cout;
        overflow <= ovf;
        zero     <= (res_fin == '0);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_serial_acc.md
# alu_serial_acc

Parametrised, digit-serial accumulator ALU. It extends the 8-bit add/subtract datapath to a configurable width, adds logic, load and clear modes, and keeps a registered accumulator with status flags. Operations enter through a valid/ready handshake and are processed DIGIT bits per cycle, least-significant digit first, so adder area stays small as WIDTH grows. It sits between the operand/opcode source and the result consumer of the ALU top level.

## Interface
Parameters:
- WIDTH, default 8: accumulator and operand width in bits.
- DIGIT, default 2: bits processed per cycle. WIDTH % DIGIT must be 0; otherwise elaboration fails.
- N = WIDTH/DIGIT: derived localparam, the number of RUN cycles.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an op is presented.
- in_ready  out  1  high exactly when the FSM is in IDLE.
- op  in  3  opcode, encoding listed under Operation.
- operand  in  WIDTH  B operand.
- acc  out  WIDTH  accumulator value (A operand and result).
- out_valid  out  1  one-cycle pulse when acc and the flags are updated.
- carry  out  1  carry flag.
- overflow  out  1  signed overflow flag.
- zero  out  1  high when the result is 0.

## Operation
Opcodes:
- 0 ADD: acc + operand.
- 1 SUB: acc + ~operand + 1.
- 2 AND, 3 OR, 4 XOR: bitwise acc with operand.
- 5 LOAD: acc = operand.
- 6 CLR: acc = 0.
- 7 PASS: acc unchanged; flags recomputed.

Accept and FSM:
- An op is accepted on an edge where in_valid && in_ready. op and operand are latched at that edge.
- Changes on op or operand after acceptance have no effect.
- in_valid outside IDLE is ignored; nothing is queued.
- FSM states: IDLE → RUN on accept.
- RUN lasts N cycles. A digit counter runs 0..N-1, and each cycle one DIGIT slice of acc and operand passes through the slice.
- The carry is held in a register between digits. Its initial value is 1 for SUB and 0 otherwise.
- Partial result digits shift into a result register.
- RUN → DONE at the edge where counter == N-1. At that same edge acc, carry, overflow and zero are written.
- DONE → IDLE unconditionally after 1 cycle. out_valid = (state == DONE).

Flags:
- ADD: carry = carry-out of the MSB.
- SUB: carry = carry-out of the MSB, which means no borrow (acc >= operand, unsigned).
- AND, OR, XOR, LOAD, CLR, PASS: carry = 0.
- overflow (ADD/SUB only) = carry into MSB XOR carry out of MSB. It is 0 for all other ops.
- zero = (new acc == 0), evaluated after any saturation.
- Without saturation, arithmetic wraps modulo 2^WIDTH.

Reset:
- rst at any edge, including mid-RUN or in DONE, forces IDLE.
- The reset edge clears acc, carry, overflow, zero and the digit counter.
- No out_valid pulse is produced for an aborted op.
- rst has priority over an accept on the same edge.

## Timing
- Reset values: acc = 0, carry = 0, overflow = 0, zero = 0, out_valid = 0, in_ready = 1.
- Latency: accept at edge T0. acc and flags update at edge T0+N. out_valid is high for the cycle between T0+N and T0+N+1.
- in_ready returns high at T0+N+1.
- Throughput: one op per N+1 cycles.
- acc, flags and out_valid are registered. in_ready is decoded directly from state.
- acc and the flags hold their values from the end of DONE until the next update.

## Configuration
- ALU_SAT_EN defined: on ADD/SUB signed overflow, acc clamps.
  - Clamp value is 0 followed by WIDTH-1 ones when the true result is positive.
  - Clamp value is 1 followed by WIDTH-1 zeros when the true result is negative.
  - overflow stays 1, and carry is still reported as computed.
- ALU_SAT_EN undefined: wrap-around only, with no clamp logic.
- Logic ops, LOAD, CLR and PASS are unaffected either way.

## Structure
- Package alu_pkg holds:
  - the op encoding (typedef enum logic [2:0]: OP_ADD … OP_PASS);
  - the FSM state typedef (ST_IDLE, ST_RUN, ST_DONE).
- Sub-module alu_digit_slice: combinational, DIGIT bits wide.
  - Inputs: a, b, cin, op.
  - Outputs: result digit, cout, and the carry into its top bit, used for the overflow computation.
  - The adder path is a full-adder ripple chain, and b is XOR-inverted for SUB.
- alu_serial_acc contains the FSM, digit counter, shift registers, carry register, flag logic and saturation.

## Test plan
All scenarios use WIDTH=8, DIGIT=2 (N=4).
- Reset, then LOAD 0x7F, then ADD 0x01 → acc 0x80, overflow 1, carry 0, zero 0. out_valid is high exactly 4 edges after the ADD accept, for one cycle.
- LOAD 0x05, SUB 0x05 → acc 0x00, zero 1, carry 1. Then SUB 0x01 → acc 0xFF, carry 0, overflow 0.
- LOAD 0xF0, XOR 0xFF → acc 0x0F, carry 0, overflow 0. Then CLR → acc 0x00, zero 1.
- With ALU_SAT_EN: LOAD 0x7F, ADD 0x01 → acc 0x7F, overflow 1. LOAD 0x80, SUB 0x01 → acc 0x80, overflow 1.
- LOAD 0x10, then ADD 0x22 with rst pulsed during its second RUN cycle → acc 0x00, no out_valid, in_ready 1 after the reset edge.
- in_valid held high continuously with the operand changing every cycle → exactly one accept per 5 cycles, and each result uses the operand present at its accept edge.
